// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU control-step sequencer: step states, request modes
// and a small index range helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_Y    = 3'd1,
    ST_OP   = 3'd2,
    ST_LO   = 3'd3,
    ST_HI   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_BIN   = 2'd0;
  localparam logic [1:0] MODE_UNARY = 2'd1;
  localparam logic [1:0] MODE_WIDE  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
    return (idx < n) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/alu_step_sequencer_onehot_dec.sv
// Register-index to one-hot strobe decoder; valid flags indices beyond the
// register file, independent of the enable.
module onehot_dec #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] vec,
  output logic         valid
);

  // one-hot decode, suppressed when disabled or out of range
  always_comb begin
    valid = (32'(idx) < 32'(N)) ? 1'b1 : 1'b0;
    for (int i = 0; i < N; i++) begin
      vec[i] = en & valid & (idx == W'(i));
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Control-step generator: sequences bus/Y/Z/HI/LO strobes for one ALU
// instruction per handshake; all outputs come straight from flops.
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int OP_W     = 5,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [OP_W-1:0]     op_code,
  input  logic [IDX_W-1:0]    ra,
  input  logic [IDX_W-1:0]    rb,
  input  logic [IDX_W-1:0]    rc,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [OP_W-1:0]     alu_op
);

  state_t              state_r, state_nxt_s;
  logic [1:0]          mode_r, mode_nxt_s;
  logic [OP_W-1:0]     op_r, op_nxt_s;
  logic [IDX_W-1:0]    ra_r, rb_r, rc_r, ra_nxt_s, rb_nxt_s, rc_nxt_s;
  logic [IDX_W-1:0]    out_idx_s, in_idx_s;
  logic                out_en_s, in_en_s, out_valid_s, in_valid_s;
  logic [NUM_REGS-1:0] out_vec_s, in_vec_s;
  logic                accept_s, reject_s;

  logic                busy_r, done_r, err_r, yin_r, zin_r, zlo_r, zhi_r, hin_r, lin_r;
  logic [NUM_REGS-1:0] reg_out_r, reg_in_r, reg_out_nxt_s;
  logic [OP_W-1:0]     alu_op_r;

  // Decoder operands come from the current state so the range check in IDLE
  // never depends on the next-state decision.
  always_comb begin
    out_idx_s = rb_r;
    out_en_s  = 1'b0;
    in_idx_s  = ra_r;
    in_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        out_idx_s = rb;
        out_en_s  = 1'b1;
        in_idx_s  = ra;
      end
      ST_Y:    begin
        out_idx_s = rc_r;
        out_en_s  = 1'b1;
      end
      ST_OP:   in_en_s = (mode_r != MODE_WIDE) ? 1'b1 : 1'b0;
      default: out_en_s = 1'b0;
    endcase
  end

  onehot_dec #(.N(NUM_REGS), .W(IDX_W)) u_out_dec (
    .idx(out_idx_s), .en(out_en_s), .vec(out_vec_s), .valid(out_valid_s)
  );

  onehot_dec #(.N(NUM_REGS), .W(IDX_W)) u_in_dec (
    .idx(in_idx_s), .en(in_en_s), .vec(in_vec_s), .valid(in_valid_s)
  );

  // next-state and request latch
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    op_nxt_s    = op_r;
    ra_nxt_s    = ra_r;
    rb_nxt_s    = rb_r;
    rc_nxt_s    = rc_r;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_nxt_s = mode;
          op_nxt_s   = op_code;
          ra_nxt_s   = ra;
          rb_nxt_s   = rb;
          rc_nxt_s   = rc;
          if ((mode == MODE_RSVD) || !out_valid_s || !in_valid_s ||
              !idx_in_range(32'(rc), 32'(NUM_REGS))) begin
            reject_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            state_nxt_s = (mode == MODE_UNARY) ? ST_OP : ST_Y;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_Y:    state_nxt_s = ST_OP;
      ST_OP:   state_nxt_s = ST_LO;
      ST_LO:   state_nxt_s = (mode_r == MODE_WIDE) ? ST_HI : ST_IDLE;
      ST_HI:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // an IDLE cycle that does not accept must not leak the rb decode
  always_comb begin
    if ((state_r == ST_IDLE) && !accept_s) begin
      reg_out_nxt_s = '0;
    end else begin
      reg_out_nxt_s = out_vec_s;
    end
  end

  // state, request and output registers
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_r   <= ST_IDLE;
      mode_r    <= 2'd0;
      op_r      <= '0;
      ra_r      <= '0;
      rb_r      <= '0;
      rc_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      yin_r     <= 1'b0;
      zin_r     <= 1'b0;
      zlo_r     <= 1'b0;
      zhi_r     <= 1'b0;
      hin_r     <= 1'b0;
      lin_r     <= 1'b0;
      reg_out_r <= '0;
      reg_in_r  <= '0;
      alu_op_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      mode_r    <= mode_nxt_s;
      op_r      <= op_nxt_s;
      ra_r      <= ra_nxt_s;
      rb_r      <= rb_nxt_s;
      rc_r      <= rc_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= ((state_nxt_s == ST_LO) && (mode_nxt_s != MODE_WIDE)) || (state_nxt_s == ST_HI);
      err_r     <= reject_s;
      yin_r     <= (state_nxt_s == ST_Y);
      zin_r     <= (state_nxt_s == ST_OP);
      zlo_r     <= (state_nxt_s == ST_LO);
      zhi_r     <= (state_nxt_s == ST_HI);
      hin_r     <= (state_nxt_s == ST_HI);
      lin_r     <= (state_nxt_s == ST_LO) && (mode_nxt_s == MODE_WIDE);
      reg_out_r <= reg_out_nxt_s;
      reg_in_r  <= in_vec_s;
      alu_op_r  <= (state_nxt_s == ST_OP) ? op_nxt_s : '0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign Yin      = yin_r;
  assign Zin      = zin_r;
  assign Zlowout  = zlo_r;
  assign Zhighout = zhi_r;
  assign HIin     = hin_r;
  assign LOin     = lin_r;
  assign reg_out  = reg_out_r;
  assign reg_in   = reg_in_r;
  assign alu_op   = alu_op_r;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer (12 registers): directed scenarios plus random
// traffic, every cycle compared against a step-list reference model.
module tb_alu_step_sequencer;

  localparam int NR = 12;

  logic          Clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [4:0]    op_code = 5'd0;
  logic [3:0]    ra = 4'd0, rb = 4'd0, rc = 4'd0;
  logic          busy, done, err, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [NR-1:0] reg_out, reg_in;
  logic [4:0]    alu_op;

  alu_step_sequencer #(.NUM_REGS(NR), .OP_W(5)) dut (
    .Clock(Clock), .clear(clear), .start(start), .mode(mode), .op_code(op_code),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .err(err),
    .reg_out(reg_out), .reg_in(reg_in), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .alu_op(alu_op)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic          busy, done, err;
    logic [NR-1:0] rout, rin;
    logic          yin, zin, zlo, zhi, hin, lin;
    logic [4:0]    op;
  } snap_t;

  snap_t cur = '0;
  snap_t obs;
  snap_t exp_q[$];
  int    checks = 0, errors = 0, cyc = 0, n_acc = 0, n_err = 0;
  logic  prev_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  // Expand one request into the strobes of each step it should produce.
  task automatic build(input logic [1:0] m, input logic [4:0] op, input logic [3:0] a, b, c);
    snap_t s;
    if (m == 2'd3 || a >= NR || b >= NR || c >= NR) begin
      s = '0; s.err = 1'b1; exp_q.push_back(s);
    end else begin
      if (m != 2'd1) begin
        s = '0; s.busy = 1'b1; s.rout = 12'b1 << b; s.yin = 1'b1; exp_q.push_back(s);
      end
      s = '0; s.busy = 1'b1; s.rout = 12'b1 << ((m == 2'd1) ? b : c);
      s.zin = 1'b1; s.op = op; exp_q.push_back(s);
      s = '0; s.busy = 1'b1; s.zlo = 1'b1;
      if (m == 2'd2) s.lin = 1'b1;
      else begin s.rin = 12'b1 << a; s.done = 1'b1; end
      exp_q.push_back(s);
      if (m == 2'd2) begin
        s = '0; s.busy = 1'b1; s.zhi = 1'b1; s.hin = 1'b1; s.done = 1'b1; exp_q.push_back(s);
      end
    end
  endtask

  task automatic model_edge();
    if (!clear) begin
      exp_q.delete();
      cur = '0;
    end else begin
      if (!cur.busy && start) build(mode, op_code, ra, rb, rc);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '0;
    end
  endtask

  task automatic cycle(input logic s, input logic [1:0] m, input logic [4:0] op,
                       input logic [3:0] a, b, c, input logic clr, input string tag);
    @(negedge Clock);
    start = s; mode = m; op_code = op; ra = a; rb = b; rc = c; clear = clr;
    @(posedge Clock);
    model_edge();
    #1;
    cyc++;
    obs = {busy, done, err, reg_out, reg_in, Yin, Zin, Zlowout, Zhighout, HIin, LOin, alu_op};
    check(tag, 64'(obs), 64'(cur));
    if (busy && !prev_busy) n_acc++;
    if (err) n_err++;
    prev_busy = busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1, "idle");
  endtask

  int a0, e0;
  logic [3:0] ri [3];

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 5'd3, 4'd1, 4'd2, 4'd3, 1'b0, "reset");
    idle(2);

    cycle(1'b1, 2'd0, 5'b00011, 4'd6, 4'd7, 4'd3, 1'b1, "binary");
    idle(4);
    cycle(1'b1, 2'd1, 5'b01001, 4'd6, 4'd7, 4'd0, 1'b1, "unary");
    idle(3);
    cycle(1'b1, 2'd2, 5'b10110, 4'd0, 4'd2, 4'd4, 1'b1, "wide");
    idle(5);

    // start held through a running binary op
    cycle(1'b1, 2'd0, 5'd7, 4'd1, 4'd2, 4'd5, 1'b1, "hold0");
    a0 = n_acc; e0 = n_err;
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'd0, 5'd7, 4'd1, 4'd2, 4'd5, 1'b1, "hold");
    idle(4);
    check("hold_accepts", 64'(n_acc - a0), 64'd2);
    check("hold_errs", 64'(n_err - e0), 64'd0);

    cycle(1'b1, 2'd0, 5'd1, 4'd13, 4'd2, 4'd3, 1'b1, "bad_ra");
    idle(2);
    cycle(1'b1, 2'd3, 5'd1, 4'd1, 4'd2, 4'd3, 1'b1, "rsvd");
    idle(2);
    cycle(1'b1, 2'd1, 5'd2, 4'd1, 4'd2, 4'd15, 1'b1, "bad_rc");
    idle(2);

    // clear while T_OP is showing, then a fresh request
    cycle(1'b1, 2'd0, 5'd4, 4'd5, 4'd8, 4'd9, 1'b1, "abort_acc");
    cycle(1'b0, 2'd0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1, "abort_y");
    cycle(1'b1, 2'd0, 5'd4, 4'd5, 4'd8, 4'd9, 1'b0, "abort_clr");
    cycle(1'b0, 2'd0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1, "abort_post");
    cycle(1'b1, 2'd0, 5'd12, 4'd11, 4'd0, 4'd10, 1'b1, "fresh");
    idle(4);

    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++)
        ri[k] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      cycle(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 5'($urandom),
            ri[0], ri[1], ri[2], ($urandom_range(0, 29) != 0), "rand");
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Parametrised control-step generator for the register-transfer datapath. It accepts one ALU instruction (opcode, destination, sources, mode) per handshake and sequences the bus-out/bus-in/Y/Z/HI/LO strobes for it, one control step per clock. It sits between instruction decode and `data_path`, replacing hand-sequenced strobes. Binary, unary and wide (HI/LO) operations are supported at any register-file size.

## Interface
- NUM_REGS, 16, number of general registers (2..32)
- OP_W, 5, ALU opcode width
- IDX_W, $clog2(NUM_REGS), register index width (derived, not overridden)

- Clock  in  1  single clock; all state changes on rising edge
- clear  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only while busy=0
- mode  in  2  0=binary, 1=unary, 2=wide, 3=reserved
- op_code  in  OP_W  ALU opcode
- ra  in  IDX_W  destination register (binary/unary)
- rb  in  IDX_W  first source (Y operand for binary, sole operand for unary/wide-A)
- rc  in  IDX_W  second source
- busy  out  1  high from first step through last step
- done  out  1  one-cycle pulse in last step
- err  out  1  one-cycle pulse when a request is rejected
- reg_out  out  NUM_REGS  one-hot Rnout strobes
- reg_in  out  NUM_REGS  one-hot Rnin strobes
- Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes
- alu_op  out  OP_W  opcode to ALU

## Operation
- States: IDLE, T_Y, T_OP, T_LO, T_HI. Moore outputs decoded from registered state plus latched request; no input-to-output combinational paths.
- IDLE, with clear=1 and start=1: latch mode/op_code/ra/rb/rc.
  - Mode 3, or any index >= NUM_REGS: stay IDLE and pulse err next cycle.
  - Otherwise the next state is T_Y for binary or wide, and T_OP for unary.
- T_Y: reg_out[rb]=1, Yin=1.
- T_OP: reg_out[src]=1, where src is rc for binary/wide and rb for unary. Zin=1, alu_op=latched op.
- T_LO: Zlowout=1. Binary/unary: reg_in[ra]=1, done=1, then go to IDLE. Wide: LOin=1, then go to T_HI.
- T_HI (wide only): Zhighout=1, HIin=1, done=1, then go to IDLE.
- alu_op is 0 in every state except T_OP.
- At most one reg_out bit and one reg_in bit are high in any cycle.
- rb=rc and ra equal to a source are legal; no hazard, since each register drives the bus in a different step.
- start while busy=1 is ignored: no latch, no err.
- Reset values (clear=0 at an edge): state IDLE, all outputs 0, latched request cleared.

## Timing
- Request accepted at edge E0. Steps occupy the cycles after E1, E2, … .
- Latency from accept to done:
  - binary: 3 cycles (T_Y, T_OP, T_LO)
  - unary: 2 cycles (T_OP, T_LO)
  - wide: 4 cycles (T_Y, T_OP, T_LO, T_HI)
- busy falls in the cycle after done. The next start is accepted in that IDLE cycle, so binary throughput is 1 op / 4 cycles.
- err is asserted in the cycle after the rejected start. busy stays 0.
- clear=0 mid-operation: outputs are 0 from the next edge, with no done and no err. The aborted request is lost.
- clear=0 and start=1 in the same cycle: clear wins, and the request is not latched.

## Structure
- Package `alu_seq_pkg`: state enum, mode constants (MODE_BIN, MODE_UNARY, MODE_WIDE, MODE_RSVD).
- Sub-module `onehot_dec` (params N, W), with inputs idx and en. Outputs:
  - a one-hot vector of width N
  - `valid`, low when idx>=N
- Two `onehot_dec` instances drive reg_out and reg_in. The valid outputs feed the err check in IDLE.

## Test plan
- Binary: op=5'b00011, ra=6, rb=7, rc=3 → one cycle each of {reg_out[7],Yin}, {reg_out[3],Zin,alu_op=3}, {Zlowout,reg_in[6],done}; then busy=0.
- Unary NOT: mode=1, op=5'b01001, ra=6, rb=7 → {reg_out[7],Zin,alu_op=9}, then {Zlowout,reg_in[6],done}; Yin never high.
- Wide: mode=2, rb=2, rc=4 → four steps, ending {Zlowout,LOin} then {Zhighout,HIin,done}; reg_in stays all-zero throughout.
- start held high for 10 cycles during a binary op → exactly 2 ops accepted (second in the IDLE cycle after done), no err.
- NUM_REGS=12, ra=13 → err pulse one cycle later, busy=0, all strobes 0. Separately, mode=3 → err.
- clear=0 during T_OP of a binary op → all outputs 0 next cycle, no done; a fresh request after release completes normally.
